regfile_dump_reader: RTL and testbench
======================================

Name: regfile_dump_reader

Overview:
Sequential read-out engine that walks all eight general-purpose registers through a register-file read port. On each step it presents one register to a downstream consumer, such as the hex-display driver or a serial debug link. It drives a 3-bit register select and samples the returned 16-bit value. It then hands each value out over a valid/ready handshake together with its register index. It sits beside the register file, on the read side, and is used for debug dumps of machine state.

Parameters:
NUM_REGS, 8, number of registers walked (indices 0..NUM_REGS-1)
DATA_W, 16, register width
ADDR_W, 3, register select width; NUM_REGS <= 2**ADDR_W

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-low reset
Start  input  1  request a full dump; sampled only in IDLE
RdAddr  output  ADDR_W  register select to register-file read port
RdData  input  DATA_W  combinational read data for RdAddr, valid same cycle
Out_Valid  output  1  Out_Data/Out_Idx hold a register value
Out_Ready  input  1  consumer accepts when Out_Valid & Out_Ready at an edge
Out_Data  output  DATA_W  captured register value
Out_Idx  output  ADDR_W  index of the register in Out_Data
Busy  output  1  high in READ, PRESENT, DONE
Done  output  1  one-cycle pulse after the last register is accepted

Behaviour:
- Reset (Reset==0 at an edge): state=IDLE, idx=0, RdAddr=0, Out_Valid=0, Out_Data=0, Out_Idx=0, Busy=0, Done=0. This applies from any state, including mid-dump; any pending output is dropped without a handshake.
- RdAddr always equals the internal idx register.
- State machine:
  - IDLE: if Start=1, then idx<=0 and go to READ. Otherwise stay.
  - READ (one cycle): Out_Data<=RdData, Out_Idx<=idx, Out_Valid<=1, go to PRESENT.
  - PRESENT: hold Out_Valid, Out_Data and Out_Idx stable until Out_Valid & Out_Ready.
    - On handshake with idx==NUM_REGS-1: Out_Valid<=0, go to DONE.
    - On handshake otherwise: idx<=idx+1, Out_Valid<=0, go to READ.
  - DONE (one cycle): Done=1, idx<=0, go to IDLE.
- Latency:
  - Start sampled at edge E0 -> READ during cycle after E0 -> Out_Valid=1 after E1.
  - Each subsequent register appears 2 cycles after the previous handshake edge.
  - Minimum full dump with Out_Ready tied high: 2*NUM_REGS+1 cycles from Start edge to Done pulse; 17 for defaults.
- Snapshot semantics: Out_Data is the register value at the READ-state edge. Register-file writes after that edge do not alter the presented value. Writes to not-yet-read registers are visible when those registers are read.
- Start is ignored while Busy=1; no queuing. Start held high continuously yields back-to-back dumps: IDLE is re-entered after DONE and Start is sampled again.
- Out_Ready while Out_Valid=0 has no effect.
- Done and Out_Valid are never high in the same cycle.
- idx never exceeds NUM_REGS-1. No wrap occurs inside a dump.

Test Plan:
- Reset state: preload R0..R7 = 16'h1110,16'h2221,...,16'h8887. Assert Reset=0 for 2 cycles -> Out_Valid=0, Busy=0, Done=0, RdAddr=0, Out_Data=0.
- Full dump, Out_Ready=1: pulse Start -> eight transfers with Out_Idx 0..7 and Out_Data 16'h1110..16'h8887 in order. Out_Valid first high 2 edges after Start. Done pulses exactly once, 17 cycles after the Start edge. Busy then drops.
- Backpressure: Out_Ready=0 for 5 cycles on register 3 (value 16'h4443) -> Out_Valid, Out_Data=16'h4443 and Out_Idx=3 are held stable for all 5 cycles. Register 4 appears 2 cycles after Out_Ready rises.
- Snapshot: while register 2 is presented and stalled, write R2=16'hBEEF -> Out_Data stays 16'h3332. Write R6=16'hCAFE before index 6 is read -> index 6 transfers 16'hCAFE.
- Start while busy: pulse Start again at transfer 4 -> no restart; the sequence continues 5..7 and exactly one Done pulse occurs.
- Reset mid-dump: Reset=0 during PRESENT at index 5 -> next cycle Out_Valid=0, Busy=0, idx=0. A new Start begins again from Out_Idx=0.

Source files
------------

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks NUM_REGS registers through a read port and presents each value/index on a valid/ready stream
// Ports: Clk, Reset (sync, active-low), Start; RdAddr/RdData register-file read port;
// Out_Valid/Out_Ready/Out_Data/Out_Idx output stream; Busy (READ/PRESENT/DONE), Done (one-cycle end pulse).
module regfile_dump_reader #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic [ADDR_W-1:0] RdAddr,
  input  logic [DATA_W-1:0] RdData,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Out_Data,
  output logic [ADDR_W-1:0] Out_Idx,
  output logic              Busy,
  output logic              Done
);
  typedef enum logic [1:0] {IDLE, READ, PRESENT, DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  state_t state;
  logic [ADDR_W-1:0] idx;
  assign RdAddr = idx;
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
      idx <= '0;
      Out_Valid <= 1'b0;
      Out_Data <= '0;
      Out_Idx <= '0;
      Busy <= 1'b0;
      Done <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: if (Start) begin
          idx <= '0;
          Busy <= 1'b1;
          state <= READ;
        end
        READ: begin
          Out_Data <= RdData;
          Out_Idx <= idx;
          Out_Valid <= 1'b1;
          state <= PRESENT;
        end
        // Out_Valid is always high here, so Out_Ready alone completes the handshake
        PRESENT: if (Out_Ready) begin
          Out_Valid <= 1'b0;
          if (idx == LAST) begin
            Done <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
            state <= READ;
          end
        end
        DONE: begin
          idx <= '0;
          Busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: directed checks of reset, full dump timing, backpressure, snapshot, busy-start and mid-dump reset
module tb_regfile_dump_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b0;
  logic [2:0] rd_addr;
  logic [15:0] rd_data;
  logic out_valid, busy, done;
  logic [15:0] out_data;
  logic [2:0] out_idx;
  logic [15:0] rf [8];
  int tests = 0;
  int fails = 0;
  assign rd_data = rf[rd_addr];
  always #5 clk = ~clk;
  regfile_dump_reader dut (
    .Clk(clk), .Reset(rst_n), .Start(start), .RdAddr(rd_addr), .RdData(rd_data),
    .Out_Valid(out_valid), .Out_Ready(ready), .Out_Data(out_data), .Out_Idx(out_idx),
    .Busy(busy), .Done(done)
  );
  function automatic logic [15:0] init_val(input int i);
    logic [3:0] a, b;
    a = 4'(i + 1);
    b = 4'(i);
    return {a, a, a, b};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic preload;
    for (int i = 0; i < 8; i++) rf[i] = init_val(i);
  endtask
  task automatic wait_valid(input string tag);
    int c = 0;
    while (!out_valid && c < 10) begin
      tick;
      c++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask
  task automatic accept;
    ready = 1'b1;
    tick;
    ready = 1'b0;
  endtask
  initial begin
    int n, first, k, dones, done_at;
    preload;
    repeat (2) tick;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(rd_addr), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    tick;
    start = 1'b1;
    ready = 1'b1;
    tick;
    start = 1'b0;
    n = 1; first = 0; k = 0; dones = 0; done_at = 0;
    repeat (30) begin
      tick;
      n++;
      if (out_valid && first == 0) first = n;
      if (out_valid) begin
        check("d1_idx", 32'(out_idx), 32'(k));
        check("d1_data", 32'(out_data), 32'(init_val(k)));
        k++;
      end
      if (done) begin
        dones++;
        done_at = n;
        check("d1_done_excl", 32'(out_valid), 32'd0);
      end
    end
    check("d1_first", 32'(first), 32'd2);
    check("d1_count", 32'(k), 32'd8);
    check("d1_dones", 32'(dones), 32'd1);
    check("d1_done_at", 32'(done_at), 32'd17);
    check("d1_busy", 32'(busy), 32'd0);
    ready = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("d2_busy", 32'(busy), 32'd1);
    wait_valid("d2_r0");
    check("d2_r0_data", 32'(out_data), 32'h1110);
    accept;
    wait_valid("d2_r1");
    accept;
    wait_valid("d2_r2");
    check("d2_r2_idx", 32'(out_idx), 32'd2);
    rf[2] = 16'hBEEF;
    rf[6] = 16'hCAFE;
    repeat (3) tick;
    check("d2_snap_valid", 32'(out_valid), 32'd1);
    check("d2_snap_data", 32'(out_data), 32'h3332);
    accept;
    wait_valid("d2_r3");
    for (int i = 0; i < 5; i++) begin
      tick;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'h4443);
      check("bp_idx", 32'(out_idx), 32'd3);
    end
    accept;
    check("bp_gap", 32'(out_valid), 32'd0);
    tick;
    check("bp_r4_valid", 32'(out_valid), 32'd1);
    check("bp_r4_idx", 32'(out_idx), 32'd4);
    check("bp_r4_data", 32'(out_data), 32'h5554);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("sb_idx", 32'(out_idx), 32'd4);
    ready = 1'b1;
    k = 4; dones = 0;
    repeat (20) begin
      if (out_valid) begin
        check("sb_idx_seq", 32'(out_idx), 32'(k));
        check("sb_data", 32'(out_data), k == 6 ? 32'hCAFE : 32'(init_val(k)));
        k++;
      end
      if (done) begin
        dones++;
        check("sb_done_excl", 32'(out_valid), 32'd0);
      end
      tick;
    end
    ready = 1'b0;
    check("sb_count", 32'(k), 32'd8);
    check("sb_dones", 32'(dones), 32'd1);
    check("sb_busy", 32'(busy), 32'd0);
    preload;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_valid("mr_pre");
      accept;
    end
    wait_valid("mr_r5");
    check("mr_r5_idx", 32'(out_idx), 32'd5);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_addr", 32'(rd_addr), 32'd0);
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_valid("mr_r0");
    check("mr_r0_idx", 32'(out_idx), 32'd0);
    check("mr_r0_data", 32'(out_data), 32'h1110);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
